// File: rtl/fcpu_pkg.sv
// rtl/fcpu_pkg.sv - shared widths, store opcodes and the store queue entry type
package fcpu_pkg;

    localparam int DATA_W   = 16;
    localparam int RSV_ID_W = 4;
    localparam int INSTR_W  = 4;
    localparam int CDB_W    = RSV_ID_W + DATA_W;

    localparam logic [INSTR_W-1:0] I_STORE  = 4'h8;
    localparam logic [INSTR_W-1:0] I_STOREB = 4'h9;
    localparam logic [INSTR_W-1:0] I_STORER = 4'hA;
    localparam logic [INSTR_W-1:0] I_OUTPUT = 4'hB;

    typedef struct packed {
        logic                valid;
        logic [RSV_ID_W-1:0] rob_id;
        logic [INSTR_W-1:0]  opcode;
        logic [DATA_W-1:0]   data;
        logic [RSV_ID_W-1:0] data_rob_id;
        logic                data_ready;
        logic [DATA_W-1:0]   address;
        logic                addr_ready;
        logic                committed;
    } sq_entry_t;

    // The broadcast tag sits above the result data on the CDB.
    function automatic logic [RSV_ID_W-1:0] cdb_tag(input logic [CDB_W-1:0] c);
        return c[CDB_W-1 -: RSV_ID_W];
    endfunction

    function automatic logic [DATA_W-1:0] cdb_data(input logic [CDB_W-1:0] c);
        return c[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/sq_age_match.sv
// rtl/sq_age_match.sv - picks the youngest set bit of a circular match vector starting at head
module sq_age_match #(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] match_i,
    input  logic [PTR_W-1:0] head_i,
    output logic [PTR_W-1:0] idx_o,
    output logic             found_o
);

    logic [PTR_W-1:0] slot;

    // Walk oldest to youngest so the last hit wins.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        slot    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot = head_i + PTR_W'(k);
            if (match_i[slot]) begin
                idx_o   = slot;
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/store_queue.sv
// rtl/store_queue.sv - circular store queue with CDB capture, load forwarding and in-order drain
module store_queue
    import fcpu_pkg::*;
#(
    parameter int SQ_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       clear,
    input  logic                       alloc_valid,
    output logic                       alloc_ready,
    input  logic [RSV_ID_W-1:0]        alloc_rob_id,
    input  logic [INSTR_W-1:0]         alloc_opcode,
    input  logic [DATA_W-1:0]          alloc_data,
    input  logic [RSV_ID_W-1:0]        alloc_data_rob_id,
    input  logic                       alloc_data_ready,
    input  logic                       addr_valid,
    input  logic [RSV_ID_W-1:0]        addr_rob_id,
    input  logic [DATA_W-1:0]          addr,
    input  logic                       cdb_valid,
    input  logic [CDB_W-1:0]           cdb,
    input  logic                       commit_valid,
    input  logic [RSV_ID_W-1:0]        commit_id,
    input  logic                       flush,
    input  logic                       ld_valid,
    input  logic [DATA_W-1:0]          ld_address,
    output logic                       ld_hit,
    output logic                       ld_stall,
    output logic [DATA_W-1:0]          ld_data,
    output logic                       mem_valid,
    input  logic                       mem_ready,
    output logic [RSV_ID_W-1:0]        mem_rob_id,
    output logic [INSTR_W-1:0]         mem_opcode,
    output logic [DATA_W-1:0]          mem_address,
    output logic [DATA_W-1:0]          mem_data,
    output logic [$clog2(SQ_DEPTH):0]  count
);

    localparam int PTR_W = $clog2(SQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    sq_entry_t        entries_q [SQ_DEPTH];
    sq_entry_t        entries_d [SQ_DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d, ncommit;
    sq_entry_t        head_e, new_e;
    logic             push, pop, cdb_hit_alloc;
    logic [SQ_DEPTH-1:0] ld_match, unresolved;
    logic [PTR_W-1:0] ld_idx;
    logic             ld_found;

    assign head_e      = entries_q[head_q];
    assign count       = count_q;
    assign alloc_ready = (count_q < CNT_W'(SQ_DEPTH)) && !flush;
    assign mem_valid   = head_e.valid & head_e.committed & head_e.addr_ready & head_e.data_ready;
    assign mem_rob_id  = head_e.rob_id;
    assign mem_opcode  = head_e.opcode;
    assign mem_address = head_e.address;
    assign mem_data    = head_e.data;

    assign push          = alloc_valid & alloc_ready;
    assign pop           = mem_valid & mem_ready;
    assign cdb_hit_alloc = cdb_valid && (cdb_tag(cdb) == alloc_data_rob_id);

    always_comb begin
        new_e             = '0;
        new_e.valid       = 1'b1;
        new_e.rob_id      = alloc_rob_id;
        new_e.opcode      = alloc_opcode;
        new_e.data_rob_id = alloc_data_rob_id;
        new_e.data_ready  = alloc_data_ready | cdb_hit_alloc;
        new_e.data        = (!alloc_data_ready && cdb_hit_alloc) ? cdb_data(cdb) : alloc_data;
    end

    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        ncommit   = '0;
        for (int i = 0; i < SQ_DEPTH; i++) begin
            if (entries_q[i].valid) begin
                if (!entries_q[i].data_ready && cdb_valid &&
                    entries_q[i].data_rob_id == cdb_tag(cdb)) begin
                    entries_d[i].data       = cdb_data(cdb);
                    entries_d[i].data_ready = 1'b1;
                end
                if (addr_valid && entries_q[i].rob_id == addr_rob_id) begin
                    entries_d[i].address    = addr;
                    entries_d[i].addr_ready = 1'b1;
                end
                if (commit_valid && entries_q[i].rob_id == commit_id) begin
                    entries_d[i].committed = 1'b1;
                end
            end
        end
        if (pop) begin
            entries_d[head_q] = '0;
            head_d            = head_q + PTR_W'(1);
        end
        // Committed entries are contiguous from head, so the survivors of a flush end at head+ncommit.
        if (flush) begin
            for (int i = 0; i < SQ_DEPTH; i++) begin
                if (entries_d[i].valid && !entries_d[i].committed) begin
                    entries_d[i] = '0;
                end else if (entries_d[i].valid) begin
                    ncommit = ncommit + CNT_W'(1);
                end
            end
            tail_d  = head_d + ncommit[PTR_W-1:0];
            count_d = ncommit;
        end else begin
            if (push) begin
                entries_d[tail_q] = new_e;
                tail_d            = tail_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_comb begin
        for (int i = 0; i < SQ_DEPTH; i++) begin
            ld_match[i]   = entries_q[i].valid && entries_q[i].addr_ready &&
                            (entries_q[i].address == ld_address);
            unresolved[i] = entries_q[i].valid && !entries_q[i].addr_ready;
        end
    end

    sq_age_match #(.DEPTH(SQ_DEPTH)) u_age_match (
        .match_i (ld_match),
        .head_i  (head_q),
        .idx_o   (ld_idx),
        .found_o (ld_found)
    );

    always_comb begin
        ld_hit   = 1'b0;
        ld_stall = 1'b0;
        ld_data  = '0;
        if (ld_valid) begin
            if (|unresolved) begin
                ld_stall = 1'b1;
            end else if (ld_found) begin
                if (entries_q[ld_idx].data_ready) begin
                    ld_hit  = 1'b1;
                    ld_data = entries_q[ld_idx].data;
                end else begin
                    ld_stall = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < SQ_DEPTH; i++) entries_q[i] <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < SQ_DEPTH; i++) entries_q[i] <= entries_d[i];
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: doc/store_queue.md
STORE_QUEUE -- requirements
Module: store_queue

Interface
REQ-001 Parameter SQ_DEPTH, default 4, entry count; SHALL be a power of two >= 2.
REQ-002 DATA_W, RSV_ID_W, INSTR_W and CDB_W SHALL come from fcpu_pkg; CDB_W = RSV_ID_W+DATA_W, with the tag in the upper bits.
REQ-003 Ports:
- clk  in  1  sole clock
- clear  in  1  synchronous active-high reset
- alloc_valid / alloc_ready  in / out  1  allocate handshake
- alloc_rob_id  in  RSV_ID_W  store tag
- alloc_opcode  in  INSTR_W  store opcode
- alloc_data  in  DATA_W  store data
- alloc_data_rob_id  in  RSV_ID_W  producer tag of the data
- alloc_data_ready  in  1  alloc_data is valid
- addr_valid  in  1  address resolution strobe
- addr_rob_id  in  RSV_ID_W  tag being resolved
- addr  in  DATA_W  resolved address
- cdb_valid, cdb  in  1, CDB_W  result broadcast
- commit_valid, commit_id  in  1, RSV_ID_W  in-order commit
- flush  in  1  discard uncommitted entries
- ld_valid, ld_address  in  1, DATA_W  load query
- ld_hit, ld_stall, ld_data  out  1, 1, DATA_W  load query result
- mem_valid / mem_ready  out / in  1  drain handshake
- mem_rob_id, mem_opcode, mem_address, mem_data  out  as named  drain payload
- count  out  $clog2(SQ_DEPTH)+1  occupancy

Function
REQ-004 Each entry SHALL hold valid, rob_id, opcode, data, data_rob_id, data_ready, address, addr_ready and committed, organised as a circular FIFO with head/tail pointers that wrap modulo SQ_DEPTH.
REQ-005 alloc_ready SHALL be (count < SQ_DEPTH) && !flush, computed from registered state only; a pop in the same cycle SHALL NOT free the slot for that cycle.
REQ-006 Allocation SHALL write the entry at tail and advance tail by one; addr_ready=0 and committed=0.
- Same-cycle allocation with cdb_valid and cdb tag == alloc_data_rob_id: the entry SHALL capture the cdb data with data_ready=1.
REQ-007 Data capture: each valid entry with data_ready=0 and data_rob_id == cdb tag SHALL latch the cdb data and set data_ready on the next edge.
REQ-008 Address resolution: the valid entry with rob_id == addr_rob_id SHALL latch addr and set addr_ready; an unmatched addr_valid SHALL be ignored.
REQ-009 Commit: the valid entry with rob_id == commit_id SHALL set committed; committed entries are always contiguous from head.
REQ-010 Drain: mem_valid SHALL be head.valid & committed & addr_ready & data_ready, driven from registered state, with the payload taken from head; mem_valid & mem_ready SHALL pop head (clearing the entry) and advance head.
REQ-011 Load query (combinational, same cycle):
- Older-store scope: all valid entries.
- ld_stall=1 if any valid entry has addr_ready=0.
- Otherwise select the youngest entry, by age from head, with address == ld_address.
- Selected entry has data_ready=1: ld_hit=1 and ld_data = its data.
- Selected entry has data_ready=0: ld_stall=1.
- No match: ld_hit=0, ld_stall=0 (load may go to memory).
- All three outputs SHALL be 0 when ld_valid=0.
REQ-012 Flush SHALL invalidate every uncommitted entry and set tail = head + (number of committed entries) mod SQ_DEPTH on the next edge.
- Same-cycle commit SHALL count as committed.
- Same-cycle pop SHALL still occur.
- Same-cycle alloc_valid SHALL be dropped.
REQ-013 count SHALL equal the number of valid entries and SHALL update on the edge following push, pop or flush; simultaneous push and pop SHALL leave count unchanged.

Reset
REQ-014 While clear=1 on a rising edge, all entries, head, tail and count SHALL become 0.
REQ-015 In the cycle after reset: mem_valid=0, alloc_ready=1, count=0; ld_* outputs SHALL be 0 when ld_valid=0.
REQ-016 clear asserted mid-drain SHALL abandon the pending store with no pop side effects.

Structure
REQ-017 The sq_entry_t typedef and the store opcode constants (I_STORE, I_STOREB, I_STORER, I_OUTPUT) SHALL reside in fcpu_pkg.
REQ-018 The youngest-match priority search SHALL be one sub-module, sq_age_match: inputs are the match vector and head; outputs are the index and a found flag.

Verification
REQ-019 Fill with SQ_DEPTH=4 stores, pop one while alloc_valid=1 -> alloc_ready=0 in that cycle and count goes 4->3; allocation succeeds next cycle.
REQ-020 Stores A(addr 0x10, data 1) and B(addr 0x10, data 2), both resolved; ld_address=0x10 -> ld_hit=1, ld_data=2.
REQ-021 Store with addr_ready=0 present; query 0x20 -> ld_stall=1; after resolving it to 0x30 -> ld_hit=0, ld_stall=0.
REQ-022 Three stores, first committed, flush -> count=1, tail=head+1; only the committed store drains with mem_valid=1.
REQ-023 Allocate a store with data_rob_id=5 while cdb_valid=1, cdb tag 5, data 0xAB -> entry data_ready=1, data=0xAB.
REQ-024 Wrap-around: 10 alloc/commit/drain cycles at SQ_DEPTH=4 -> in-order mem_rob_id sequence, no loss, count returns to 0.
